// File: rtl/mc_pkg.sv
// Shared missile-command constants: grid limits, cursor width, fire FSM encoding, 50 MHz timing.
package mc_pkg;

  localparam int GRID_X_MAX = 3;
  localparam int GRID_Y_MAX = 2;
  localparam int CURSOR_W   = 4;
  localparam int AMMO_W     = 4;

  localparam int CLK_HZ           = 50_000_000;
  localparam int DEBOUNCE_CYC_DEF = CLK_HZ / 100;  // 10 ms
  localparam int COOLDOWN_CYC_DEF = CLK_HZ / 2;    // 0.5 s
  localparam int AMMO_MAX_DEF     = 10;

  typedef enum logic [1:0] {
    FIRE_IDLE     = 2'd0,
    FIRE_REQ      = 2'd1,
    FIRE_COOLDOWN = 2'd2
  } fire_state_e;

  function automatic logic cursor_in_range(input logic [CURSOR_W-1:0] x,
                                           input logic [CURSOR_W-1:0] y);
    return (x <= CURSOR_W'(GRID_X_MAX)) && (y <= CURSOR_W'(GRID_Y_MAX));
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronises an active-low raw button, debounces its level and emits a 1-cycle press pulse.
module button_debounce
  import mc_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic             sync1_q, sync2_q;
  logic             level_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;
  logic             flip_d;

  // Level flips on the DEBOUNCE_CYC-th consecutive cycle of disagreement.
  assign flip_d = (sync2_q != level_q) && (cnt_q == CNT_W'(DEBOUNCE_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
      press_q <= flip_d & level_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (flip_d) begin
        cnt_q   <= '0;
        level_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/fire_control.sv
// Turns debounced fire presses into launch requests at the latched cursor cell,
// with ammunition tracking and a fixed cooldown after every accepted launch.
module fire_control
  import mc_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int COOLDOWN_CYC = COOLDOWN_CYC_DEF,
  parameter int AMMO_MAX     = AMMO_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                player_fire,
  input  logic [CURSOR_W-1:0] player_cursor_x_reg,
  input  logic [CURSOR_W-1:0] player_cursor_y_reg,
  input  logic                reload,
  input  logic                launch_ready,
  output logic                launch_valid,
  output logic [CURSOR_W-1:0] launch_x,
  output logic [CURSOR_W-1:0] launch_y,
  output logic [AMMO_W-1:0]   ammo_count,
  output logic                fire_busy,
  output logic                fire_reject
);

  localparam int COOL_W = $clog2(COOLDOWN_CYC + 1);

  fire_state_e         state_q;
  logic                valid_q, busy_q, reject_q;
  logic [CURSOR_W-1:0] x_q, y_q;
  logic [AMMO_W-1:0]   ammo_q;
  logic [COOL_W-1:0]   cool_q;
  logic                press;

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_fire_db (
    .clk     (clk),
    .rst     (rst),
    .btn_n_i (player_fire),
    .press_o (press)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= FIRE_IDLE;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      reject_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      ammo_q   <= AMMO_W'(AMMO_MAX);
      cool_q   <= '0;
    end else begin
      reject_q <= 1'b0;
      case (state_q)
        FIRE_IDLE: begin
          if (press) begin
            if (ammo_q == '0 || !cursor_in_range(player_cursor_x_reg, player_cursor_y_reg)) begin
              reject_q <= 1'b1;
            end else begin
              x_q     <= player_cursor_x_reg;
              y_q     <= player_cursor_y_reg;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= FIRE_REQ;
            end
          end
        end
        FIRE_REQ: begin
          if (launch_ready) begin
            valid_q <= 1'b0;
            ammo_q  <= ammo_q - 1'b1;
            cool_q  <= '0;
            state_q <= FIRE_COOLDOWN;
          end
        end
        FIRE_COOLDOWN: begin
          if (cool_q == COOL_W'(COOLDOWN_CYC - 1)) begin
            busy_q  <= 1'b0;
            state_q <= FIRE_IDLE;
          end else begin
            cool_q <= cool_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state_q <= FIRE_IDLE;
        end
      endcase
      // Later assignment wins, so a reload on the transfer edge overrides the decrement.
      if (reload) begin
        ammo_q <= AMMO_W'(AMMO_MAX);
      end
    end
  end

  assign launch_valid = valid_q;
  assign launch_x     = x_q;
  assign launch_y     = y_q;
  assign ammo_count   = ammo_q;
  assign fire_busy    = busy_q;
  assign fire_reject  = reject_q;

endmodule
